// File: rtl/data_sram_like_responder.sv
// data_sram_like_responder: data-side sram-like bus target with in-order fixed-latency responses.
// Define DATA_SRAM_STALL_EN to force addr_ok low one cycle in four.
module data_sram_like_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int LATENCY     = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int PW1 = PW + 1;
  localparam int MEM_WORDS = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam logic [PW:0] FULL_CNT = PW1'(QUEUE_DEPTH);

  logic [31:0] mem [MEM_WORDS];
  logic [ADDR_WIDTH-1:0] idx;

  logic [QUEUE_DEPTH-1:0] q_vld;
  logic                   q_wr   [QUEUE_DEPTH];
  logic [31:0]            q_data [QUEUE_DEPTH];
  logic [3:0]             q_cnt  [QUEUE_DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic full;
  logic stall;
  logic accept;
  logic pop;
  logic unused_bits;

  assign unused_bits = ^{data_sram_size,
                         data_sram_addr[31:ADDR_WIDTH+2],
                         data_sram_addr[1:0]};

  assign idx    = data_sram_addr[ADDR_WIDTH+1:2];
  assign full   = (count == FULL_CNT);
  assign accept = data_sram_req & data_sram_addr_ok;
  assign pop    = data_sram_data_ok;

  // full blocks accept even when the head pops in the same cycle
  assign data_sram_addr_ok = ~reset & ~full & ~stall;
  assign data_sram_data_ok = q_vld[head] & (q_cnt[head] == 4'd0);
  assign data_sram_rdata   = (data_sram_data_ok & ~q_wr[head]) ?
                             q_data[head] : 32'h0;

`ifdef DATA_SRAM_STALL_EN
  logic [1:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 2'd0;
    end else begin
      stall_cnt <= stall_cnt + 2'd1;
    end
  end

  assign stall = &stall_cnt;
`else
  assign stall = 1'b0;
`endif

  // memory contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) begin
          mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      q_vld <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_wr[i]   <= 1'b0;
        q_data[i] <= '0;
        q_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (q_vld[i] && q_cnt[i] != 4'd0) begin
          q_cnt[i] <= q_cnt[i] - 4'd1;
        end
      end
      if (pop) begin
        q_vld[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (accept) begin
        q_vld[tail]  <= 1'b1;
        q_wr[tail]   <= data_sram_wr;
        q_data[tail] <= data_sram_wr ? 32'h0 : mem[idx];
        q_cnt[tail]  <= CNT_INIT;
        tail         <= tail + PW'(1);
      end
      unique case ({accept, pop})
        2'b10:   count <= count + PW1'(1);
        2'b01:   count <= count - PW1'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
